// File: rtl/wb_regfile_pkg.sv
// Pipeline-wide constants shared by decode, hazard, forwarding and write-back.
package wb_regfile_pkg;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned NUM_REGS = 32;
  localparam int unsigned ADDR_W   = 5;
  localparam int unsigned ZERO_REG = 0;
endpackage

// File: rtl/wb_regfile_reg_array.sv
// Architectural storage: one synchronous write port with async clear,
// two combinational read ports; register 0 always reads as zero.
module wb_regfile_reg_array #(
  parameter int unsigned DATA_W   = wb_regfile_pkg::DATA_W,
  parameter int unsigned NUM_REGS = wb_regfile_pkg::NUM_REGS,
  parameter int unsigned ADDR_W   = wb_regfile_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr1,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2
);
  import wb_regfile_pkg::*;

  logic [DATA_W-1:0] mem [NUM_REGS];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  always_comb begin
    rdata1 = (raddr1 == ADDR_W'(ZERO_REG)) ? '0 : mem[raddr1];
    rdata2 = (raddr2 == ADDR_W'(ZERO_REG)) ? '0 : mem[raddr2];
  end
endmodule

// File: rtl/wb_regfile.sv
// Write-back stage: result mux, register file commit with write-first
// bypass on both read ports, and a retired-write counter.
module wb_regfile #(
  parameter int unsigned DATA_W   = wb_regfile_pkg::DATA_W,
  parameter int unsigned NUM_REGS = wb_regfile_pkg::NUM_REGS,
  parameter int unsigned ADDR_W   = wb_regfile_pkg::ADDR_W,
  parameter int unsigned CNT_W    = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              RegWrite,
  input  logic              MemtoReg,
  input  logic [DATA_W-1:0] ReadData,
  input  logic [DATA_W-1:0] ALU,
  input  logic [ADDR_W-1:0] WriteReg,
  input  logic [ADDR_W-1:0] ReadReg1,
  input  logic [ADDR_W-1:0] ReadReg2,
  output logic [DATA_W-1:0] ReadData1,
  output logic [DATA_W-1:0] ReadData2,
  output logic [DATA_W-1:0] WriteData,
  output logic [CNT_W-1:0]  wb_count
);
  import wb_regfile_pkg::*;

  logic              commit;
  logic              byp1, byp2;
  logic [DATA_W-1:0] arr_rd1, arr_rd2;

  assign WriteData = MemtoReg ? ReadData : ALU;
  assign commit    = RegWrite && (WriteReg != ADDR_W'(ZERO_REG));

  // Bypass keyed on commit, so r0 and reset-held cycles never forward.
  assign byp1 = reset && commit && (WriteReg == ReadReg1);
  assign byp2 = reset && commit && (WriteReg == ReadReg2);

  wb_regfile_reg_array #(
    .DATA_W  (DATA_W),
    .NUM_REGS(NUM_REGS),
    .ADDR_W  (ADDR_W)
  ) u_reg_array (
    .clk   (clk),
    .reset (reset),
    .we    (commit),
    .waddr (WriteReg),
    .wdata (WriteData),
    .raddr1(ReadReg1),
    .raddr2(ReadReg2),
    .rdata1(arr_rd1),
    .rdata2(arr_rd2)
  );

  assign ReadData1 = byp1 ? WriteData : arr_rd1;
  assign ReadData2 = byp2 ? WriteData : arr_rd2;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wb_count <= '0;
    end else if (commit) begin
      wb_count <= wb_count + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_wb_regfile.sv
// Directed bench for wb_regfile: expectations queued at drive time, popped at check.
module tb_wb_regfile;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        reset4 = 1'b0;
  logic        RegWrite = 1'b0;
  logic        MemtoReg = 1'b0;
  logic [31:0] ReadData = '0;
  logic [31:0] ALU = '0;
  logic [4:0]  WriteReg = '0;
  logic [4:0]  ReadReg1 = '0;
  logic [4:0]  ReadReg2 = '0;
  logic [31:0] ReadData1, ReadData2, WriteData, wb_count;
  logic [31:0] rd1_4, rd2_4, wd_4;
  logic [3:0]  cnt4;

  int unsigned compared   = 0;
  int unsigned mismatched = 0;
  logic [31:0] sb_q [$];

  wb_regfile dut (
    .clk(clk), .reset(reset), .RegWrite(RegWrite), .MemtoReg(MemtoReg),
    .ReadData(ReadData), .ALU(ALU), .WriteReg(WriteReg),
    .ReadReg1(ReadReg1), .ReadReg2(ReadReg2),
    .ReadData1(ReadData1), .ReadData2(ReadData2),
    .WriteData(WriteData), .wb_count(wb_count)
  );

  wb_regfile #(.CNT_W(4)) dut4 (
    .clk(clk), .reset(reset4), .RegWrite(RegWrite), .MemtoReg(MemtoReg),
    .ReadData(ReadData), .ALU(ALU), .WriteReg(WriteReg),
    .ReadReg1(ReadReg1), .ReadReg2(ReadReg2),
    .ReadData1(rd1_4), .ReadData2(rd2_4),
    .WriteData(wd_4), .wb_count(cnt4)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic push(input logic [31:0] v);
    sb_q.push_back(v);
  endtask

  task automatic check(input string tag, input logic [31:0] observed);
    logic [31:0] expected;
    expected = sb_q.pop_front();
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Advance past the next rising edge; inputs change and outputs are sampled here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset held low: writes to every register must be ignored.
    #2;
    RegWrite = 1'b1;
    for (int unsigned r = 0; r < 32; r++) begin
      WriteReg = 5'(r);
      ALU      = 32'h100 + r;
      tick();
    end
    // While still in reset: reads are 0 even with a matching write pending.
    for (int unsigned r = 0; r < 32; r++) begin
      WriteReg = 5'(r); ReadReg1 = 5'(r); ReadReg2 = 5'(r);
      ALU = 32'hA500 + r;
      #1;
      push(32'h0); check("rst_rd1", ReadData1);
      push(32'h0); check("rst_rd2", ReadData2);
    end
    push(32'hA51F); check("rst_wdata_mux", WriteData);
    push(32'h0); check("rst_count", wb_count);
    push(32'h0); check("rst_count4", 32'(cnt4));

    RegWrite = 1'b0;
    #2 reset = 1'b1;
    tick();

    // Mux select, ALU path into r5.
    RegWrite = 1'b1; WriteReg = 5'd5; ALU = 32'h1234; ReadData = 32'hDEAD; MemtoReg = 1'b0;
    #1 push(32'h1234); check("mux_alu_wdata", WriteData);
    tick();
    RegWrite = 1'b0; ReadReg1 = 5'd5;
    #1 push(32'h1234); check("mux_alu_r5", ReadData1);
    // Memory path into r6.
    RegWrite = 1'b1; WriteReg = 5'd6; MemtoReg = 1'b1;
    #1 push(32'hDEAD); check("mux_mem_wdata", WriteData);
    tick();
    RegWrite = 1'b0; ReadReg2 = 5'd6;
    #1 push(32'hDEAD); check("mux_mem_r6", ReadData2);
    push(32'd2); check("count_after_two", wb_count);

    // Bypass on r7.
    MemtoReg = 1'b0; ALU = 32'hCAFE; WriteReg = 5'd7; ReadReg1 = 5'd7; ReadReg2 = 5'd7;
    #1 push(32'h0); check("nobyp_rd1", ReadData1);
    push(32'h0); check("nobyp_rd2", ReadData2);
    RegWrite = 1'b1;
    #1 push(32'hCAFE); check("byp_rd1", ReadData1);
    push(32'hCAFE); check("byp_rd2", ReadData2);
    tick();
    RegWrite = 1'b0; ALU = 32'h0;
    #1 push(32'hCAFE); check("r7_stored_rd1", ReadData1);
    push(32'hCAFE); check("r7_stored_rd2", ReadData2);

    // Zero register.
    RegWrite = 1'b1; WriteReg = 5'd0; ALU = 32'hFFFF_FFFF; ReadReg1 = 5'd0; ReadReg2 = 5'd0;
    #1 push(32'h0); check("r0_nobyp_rd1", ReadData1);
    push(32'h0); check("r0_nobyp_rd2", ReadData2);
    tick();
    RegWrite = 1'b0;
    #1 push(32'h0); check("r0_after_rd1", ReadData1);
    push(32'd3); check("r0_count_same", wb_count);

    // Fill r1..r31 with their own index.
    RegWrite = 1'b1;
    for (int unsigned r = 1; r < 32; r++) begin
      WriteReg = 5'(r); ALU = r;
      tick();
    end
    RegWrite = 1'b0;
    for (int unsigned r = 1; r < 32; r++) begin
      ReadReg1 = 5'(r); ReadReg2 = 5'(32 - r);
      #1;
      push(r);      check("fill_rd1", ReadData1);
      push(32 - r); check("fill_rd2", ReadData2);
    end
    push(32'd34); check("fill_count", wb_count);

    // Async reset between edges, with a write to r3 pending.
    RegWrite = 1'b1; WriteReg = 5'd3; ALU = 32'h33;
    #2 reset = 1'b0;
    #1;
    for (int unsigned r = 0; r < 32; r++) begin
      ReadReg1 = 5'(r); ReadReg2 = 5'(31 - r);
      #0;
      push(32'h0); check("async_rd1", ReadData1);
      push(32'h0); check("async_rd2", ReadData2);
    end
    push(32'h0); check("async_count", wb_count);
    tick();
    RegWrite = 1'b0; ReadReg1 = 5'd3;
    #2 reset = 1'b1;
    #1 push(32'h0); check("dropped_r3", ReadData1);
    push(32'h0); check("dropped_count", wb_count);

    // Counter wrap on the 4-bit instance.
    reset4 = 1'b1;
    RegWrite = 1'b1; WriteReg = 5'd1; ALU = 32'h11;
    for (int unsigned n = 1; n <= 17; n++) begin
      tick();
      if (n == 15) begin push(32'd15); check("cnt4_15", 32'(cnt4)); end
      if (n == 16) begin push(32'd0);  check("cnt4_wrap", 32'(cnt4)); end
    end
    RegWrite = 1'b0;
    #1 push(32'd1); check("cnt4_17", 32'(cnt4));
    push(32'd17); check("cnt32_17", wb_count);
    ReadReg2 = 5'd1;
    #1 push(32'h11); check("cnt4_r1", rd2_4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
